axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameters SHALL be: MAX_OUTST, default 8, maximum outstanding read bursts; ID_W, default 6, AXI ID width.
REQ-002 m_axi_clk  in  1  clock for all logic; reset m_axi_rst, asynchronous, active-high; clock m_axi_clk.
REQ-003 m_axi_rst  in  1  asynchronous active-high reset.
REQ-004 reqN_valid / reqN_ready  in / out  1 each (N=0,1)  burst-request handshake per requester.
REQ-005 reqN_addr  in  32  burst byte address; bits [2:0] ignored.
REQ-006 reqN_len  in  4  AXI beats minus 1 (0..15).
REQ-007 rdN_valid / rdN_ready  out / in  1 each  return-data handshake per requester.
REQ-008 rdN_data / rdN_last  out  64 / 1  return beat and burst-last flag.
REQ-009 m_axi_arvalid / m_axi_arready  out / in  1 each  AR handshake.
REQ-010 m_axi_araddr / m_axi_arlen / m_axi_arid  out  32 / 4 / ID_W  AR payload.
REQ-011 m_axi_arsize / m_axi_arburst  out  3 / 2  constant 3'd3 (8 bytes) / 2'b01 (INCR).
REQ-012 m_axi_rvalid / m_axi_rready  in / out  1 each  R handshake.
REQ-013 m_axi_rdata / m_axi_rlast  in  64 / 1  R payload.
REQ-014 err_unexp_r  out  1  sticky flag: R beat arrived with no outstanding burst.

Function
REQ-015 The FSM SHALL have two states: IDLE and ADDR.
REQ-016 In IDLE, if any reqN_valid is high and (count + 0) < MAX_OUTST, the FSM SHALL grant one requester, assert its reqN_ready in that same cycle, register its addr/len, and move to ADDR.
REQ-017 Arbitration SHALL be round-robin: with both requests valid, the grant goes to the requester not granted last; with one valid, that one is granted.
REQ-018 At most one reqN_ready SHALL be high in any cycle; reqN_ready SHALL be low outside IDLE.
REQ-019 In ADDR, m_axi_arvalid SHALL be 1 with araddr = {addr[31:3],3'b000}, arlen = len, arid = granted index zero-extended; payload SHALL be stable until arready.
REQ-020 On AR handshake, the granted index SHALL be pushed into an in-order grant FIFO and the FSM SHALL return to IDLE; latency from request handshake to arvalid is 1 cycle.
REQ-021 count SHALL be the FIFO occupancy; a new grant is blocked when count == MAX_OUTST.
REQ-022 The R path SHALL be combinational: FIFO head selects requester h; rdh_valid = m_axi_rvalid & ~empty; m_axi_rready = rdh_ready & ~empty; rdh_data/rdh_last = m_axi_rdata/m_axi_rlast; the other rd valid SHALL be 0.
REQ-023 An R handshake with m_axi_rlast=1 SHALL pop the FIFO head.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged, including when count == MAX_OUTST.
REQ-025 m_axi_rvalid while the FIFO is empty SHALL set err_unexp_r, cleared only by reset; m_axi_rready stays 0.
REQ-026 Requester deasserting reqN_valid without handshake SHALL be permitted; arbitration re-evaluates each IDLE cycle.

Reset
REQ-027 On m_axi_rst, the block SHALL: FSM to IDLE, m_axi_arvalid=0, FIFO empty, count=0, err_unexp_r=0, last grant = 1 (req0 wins first tie).
REQ-028 Reset mid-burst SHALL discard all outstanding entries; no rd valid until new grants.

Structure
REQ-029 FSM state encoding, AXI constants (ARSIZE_8B, ARBURST_INCR) and MAX_OUTST default SHALL live in the shared package lk_defines.
REQ-030 The grant FIFO SHALL be one sub-module, sync_fifo (width 1, depth MAX_OUTST, fall-through head, count output).

Verification
REQ-031 Both requests valid at reset release (addr 0x20000000 len 15, addr 0x21000000 len 15) -> AR order req0, req1, req0, ...; arid 0,1,0.
REQ-032 req0 only, 9 bursts, R stalled -> exactly 8 AR handshakes; 9th issues one cycle after first rlast pop.
REQ-033 Interleaved bursts 0,1,0 with random rvalid/rdN_ready gaps -> all 48 beats routed to correct requester, rdN_last on beats 16/32/48.
REQ-034 req1 addr 0x21000805 len 3 -> araddr 0x21000800, arlen 3, arsize 3, arburst 1.
REQ-035 rvalid=1 with no outstanding burst -> rready=0, err_unexp_r=1 next cycle and held.
REQ-036 Reset asserted with 3 bursts outstanding -> arvalid=0, count=0, all rd valid 0; first post-reset grant goes to req0.

Source files
------------

// File: rtl/lk_defines.sv
// Shared definitions for the AXI read arbiter: FSM encoding, AR constants,
// and the default outstanding-burst limit.
package lk_defines;

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } state_t;

  localparam logic [2:0] ARSIZE_8B     = 3'd3;
  localparam logic [1:0] ARBURST_INCR  = 2'b01;
  localparam int         MAX_OUTST_DEF = 8;

endpackage

// File: rtl/axi_rd_arbiter_sync_fifo.sv
// Small synchronous FIFO with fall-through head and occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR issue, in-order R return
// steered by a FIFO of granted requester indices.
module axi_rd_arbiter
  import lk_defines::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int ID_W      = 6
) (
  input  logic            m_axi_clk,
  input  logic            m_axi_rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_addr,
  input  logic [3:0]      req0_len,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_addr,
  input  logic [3:0]      req1_len,
  output logic            rd0_valid,
  input  logic            rd0_ready,
  output logic [63:0]     rd0_data,
  output logic            rd0_last,
  output logic            rd1_valid,
  input  logic            rd1_ready,
  output logic [63:0]     rd1_data,
  output logic            rd1_last,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  output logic [31:0]     m_axi_araddr,
  output logic [3:0]      m_axi_arlen,
  output logic [ID_W-1:0] m_axi_arid,
  output logic [2:0]      m_axi_arsize,
  output logic [1:0]      m_axi_arburst,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready,
  input  logic [63:0]     m_axi_rdata,
  input  logic            m_axi_rlast,
  output logic            err_unexp_r
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  state_t        state, state_nx;
  logic          last_grant;
  logic          grant_idx;
  logic [31:0]   addr_q;
  logic [3:0]    len_q;
  logic          grant;
  logic          sel;
  logic          push;
  logic          pop;
  logic          can_grant;
  logic          head;
  logic          empty;
  logic [CW-1:0] count;

  // Gate grants during reset so no requester sees a handshake that is thrown away.
  assign can_grant = ~m_axi_rst & (count < CW'(MAX_OUTST));

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    sel        = 1'b0;
    push       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (can_grant && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          req0_ready = ~sel;
          req1_ready = sel;
          state_nx   = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          push     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_idx  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last_grant <= sel;
        grant_idx  <= sel;
        addr_q     <= sel ? req1_addr : req0_addr;
        len_q      <= sel ? req1_len : req0_len;
      end
    end
  end

  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_araddr  = addr_q & ~32'h7;
  assign m_axi_arlen   = len_q;
  assign m_axi_arid    = ID_W'(grant_idx);
  assign m_axi_arsize  = ARSIZE_8B;
  assign m_axi_arburst = ARBURST_INCR;

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTST)
  ) u_grant_fifo (
    .clk   (m_axi_clk),
    .rst   (m_axi_rst),
    .push  (push),
    .din   (grant_idx),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (),
    .count (count)
  );

  // Return beats are steered purely by the oldest outstanding grant.
  assign rd0_valid    = m_axi_rvalid & ~empty & ~head;
  assign rd1_valid    = m_axi_rvalid & ~empty & head;
  assign m_axi_rready = ~empty & (head ? rd1_ready : rd0_ready);
  assign rd0_data     = m_axi_rdata;
  assign rd1_data     = m_axi_rdata;
  assign rd0_last     = m_axi_rlast;
  assign rd1_last     = m_axi_rlast;
  assign pop          = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst)                 err_unexp_r <= 1'b0;
    else if (m_axi_rvalid & empty) err_unexp_r <= 1'b1;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: requests push expected AR/R records,
// a slave/monitor process pops and compares them as the DUT produces traffic.
module tb_axi_rd_arbiter;

  localparam int ID_W = 6;

  logic            m_axi_clk = 1'b0;
  logic            m_axi_rst = 1'b1;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [31:0]     req0_addr = '0, req1_addr = '0;
  logic [3:0]      req0_len = '0, req1_len = '0;
  logic            rd0_valid, rd1_valid, rd0_last, rd1_last;
  logic            rd0_ready, rd1_ready;
  logic [63:0]     rd0_data, rd1_data;
  logic            m_axi_arvalid, m_axi_arready;
  logic [31:0]     m_axi_araddr;
  logic [3:0]      m_axi_arlen;
  logic [ID_W-1:0] m_axi_arid;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0]     m_axi_rdata;
  logic            err_unexp_r;

  axi_rd_arbiter #(.MAX_OUTST(8), .ID_W(ID_W)) dut (
    .m_axi_clk(m_axi_clk), .m_axi_rst(m_axi_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_data(rd0_data), .rd0_last(rd0_last),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_data(rd1_data), .rd1_last(rd1_last),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .err_unexp_r(err_unexp_r)
  );

  always #5 m_axi_clk = ~m_axi_clk;

  typedef struct { logic [31:0] addr; logic [3:0] len; logic id; } ar_t;
  typedef struct { logic id; logic [3:0] len; } burst_t;

  ar_t    exp_ar[$];
  burst_t rq[$];
  int     last_pos[$];
  int     checks = 0, errors = 0, cyc = 0;
  int     ar_cnt = 0, rbeat = 0, beat_total = 0, beats0 = 0, beats1 = 0;
  int     first_pop_cyc = -1;
  bit     ar_en = 1'b1, r_en = 1'b0, r_rand = 1'b0, rd_rand = 1'b0, force_rv = 1'b0;
  logic [63:0] cur_data;
  ar_t    mon_e;
  burst_t mon_b;
  logic   exp_last;
  logic   beat_ok;

  always @(posedge m_axi_clk) cyc <= cyc + 1;

  // Slave drives at +2 after the edge, monitor compares settled outputs at +4.
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    rd0_ready = 1'b0; rd1_ready = 1'b0;
    forever begin
      @(posedge m_axi_clk); #2;
      m_axi_arready = ar_en;
      cur_data = {$urandom, $urandom};
      m_axi_rdata = cur_data;
      if (force_rv) begin
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0;
      end else if (!m_axi_rst && r_en && rq.size() > 0 && (!r_rand || $urandom_range(0, 2) != 0)) begin
        m_axi_rvalid = 1'b1; m_axi_rlast = (rbeat == int'(rq[0].len));
      end else begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end
      rd0_ready = rd_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd1_ready = rd_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #2;
      if (m_axi_rst) begin
        rq.delete(); exp_ar.delete(); rbeat = 0;
      end else begin
        if (req0_ready || req1_ready) begin
          checks++;
          if ((req0_ready && req1_ready) || m_axi_arvalid) begin
            errors++;
            $display("FAIL ready_excl: req0_ready=%b req1_ready=%b arvalid=%b, need one ready and arvalid=0",
                     req0_ready, req1_ready, m_axi_arvalid);
          end
        end
        if (m_axi_arvalid && m_axi_arready) begin
          checks++;
          if (exp_ar.size() == 0) begin
            errors++;
            $display("FAIL unexp_ar: AR handshake araddr=%h with no expected request", m_axi_araddr);
          end else begin
            mon_e = exp_ar.pop_front();
            if (m_axi_araddr !== {mon_e.addr[31:3], 3'b000} || m_axi_arlen !== mon_e.len ||
                m_axi_arid !== ID_W'(mon_e.id) || m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01) begin
              errors++;
              $display("FAIL ar_payload: got addr=%h len=%0d id=%0d size=%0d burst=%0d, need addr=%h len=%0d id=%0d size=3 burst=1",
                       m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst,
                       {mon_e.addr[31:3], 3'b000}, mon_e.len, mon_e.id);
            end
            rq.push_back('{mon_e.id, mon_e.len});
            ar_cnt++;
          end
        end
        if (m_axi_rvalid && m_axi_rready) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL r_no_burst: rready=1 with no outstanding burst");
          end else begin
            mon_b = rq[0];
            exp_last = (rbeat == int'(mon_b.len));
            if (mon_b.id == 1'b0)
              beat_ok = (rd0_valid === 1'b1) && (rd1_valid === 1'b0) && (rd0_data === cur_data) && (rd0_last === exp_last);
            else
              beat_ok = (rd1_valid === 1'b1) && (rd0_valid === 1'b0) && (rd1_data === cur_data) && (rd1_last === exp_last);
            if (!beat_ok) begin
              errors++;
              $display("FAIL r_route: got v0=%b v1=%b l0=%b l1=%b, need requester %0d valid last=%b data=%h",
                       rd0_valid, rd1_valid, rd0_last, rd1_last, mon_b.id, exp_last, cur_data);
            end
            beat_total++;
            if (mon_b.id) beats1++; else beats0++;
            if (exp_last) begin
              last_pos.push_back(beat_total);
              void'(rq.pop_front());
              rbeat = 0;
              if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end else begin
              rbeat++;
            end
          end
        end else if (m_axi_rvalid && rq.size() == 0) begin
          checks++;
          if (m_axi_rready !== 1'b0) begin
            errors++;
            $display("FAIL rready_empty: got rready=%b, need 0", m_axi_rready);
          end
        end
      end
    end
  end

  task automatic clear_stats();
    beat_total = 0; beats0 = 0; beats1 = 0; last_pos.delete(); first_pop_cyc = -1;
  endtask

  task automatic do_req(input logic id, input logic [31:0] addr, input logic [3:0] len);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge m_axi_clk); #1;
      req0_valid = ~id; req1_valid = id;
      req0_addr = addr; req1_addr = addr; req0_len = len; req1_len = len;
      #2;
      if (id ? req1_ready : req0_ready) begin
        exp_ar.push_back('{addr, len, id});
        done = 1'b1;
      end
    end
    @(posedge m_axi_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL req_timeout: requester %0d got ready=0, need 1", id); end
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() > 0 || exp_ar.size() > 0 || m_axi_arvalid) && n < 3000) begin
      @(posedge m_axi_clk); #5;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: %0d bursts and %0d ARs still pending, need 0", rq.size(), exp_ar.size());
    end
  endtask

  task automatic test_reset();
    m_axi_rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h2000_0000; req0_len = 4'd15;
    req1_valid = 1'b1; req1_addr = 32'h2100_0000; req1_len = 4'd15;
    repeat (3) @(posedge m_axi_clk);
    #3;
    checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b, need 0", m_axi_arvalid); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b%b, need 00", req0_ready, req1_ready); end
    checks++; if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin errors++; $display("FAIL rst_rdvalid: got %b%b, need 00", rd0_valid, rd1_valid); end
    checks++; if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b, need 0", m_axi_rready); end
    checks++; if (err_unexp_r !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, need 0", err_unexp_r); end
  endtask

  task automatic test_round_robin();
    logic exp_ids [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic g;
    int   hs = 0;
    clear_stats();
    r_en = 1'b1; r_rand = 1'b1; rd_rand = 1'b1;
    for (int i = 0; i < 400 && hs < 4; i++) begin
      @(posedge m_axi_clk); #1;
      if (i == 0) m_axi_rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #2;
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        checks++;
        if (g !== exp_ids[hs]) begin errors++; $display("FAIL rr_order: grant %0d went to %0d, need %0d", hs, g, exp_ids[hs]); end
        exp_ar.push_back('{g ? req1_addr : req0_addr, 4'd15, g});
        hs++;
      end
    end
    @(posedge m_axi_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (hs != 4) begin errors++; $display("FAIL rr_count: got %0d grants, need 4", hs); end
    drain();
    checks++;
    if (beats0 != 32 || beats1 != 32) begin errors++; $display("FAIL rr_beats: got %0d/%0d, need 32/32", beats0, beats1); end
  endtask

  task automatic test_outstanding();
    int base, hs = 0, grant_cyc = -1;
    logic [31:0] a;
    clear_stats();
    r_en = 1'b0; r_rand = 1'b0; rd_rand = 1'b0;
    base = ar_cnt;
    for (int i = 0; i < 300 && hs < 9; i++) begin
      @(posedge m_axi_clk); #1;
      a = 32'h3000_0000 + 32'(hs * 64);
      req0_valid = 1'b1; req0_addr = a; req0_len = 4'd1;
      #2;
      if (req0_ready) begin
        exp_ar.push_back('{a, 4'd1, 1'b0});
        hs++;
        if (hs == 9) grant_cyc = cyc;
      end
      if (i == 40) begin
        checks++;
        if (ar_cnt - base != 8 || hs != 8) begin
          errors++; $display("FAIL outst_limit: got %0d AR / %0d grants with R stalled, need 8/8", ar_cnt - base, hs);
        end
        first_pop_cyc = -1;
        r_en = 1'b1;
      end
    end
    @(posedge m_axi_clk); #1;
    req0_valid = 1'b0;
    checks++;
    if (grant_cyc != first_pop_cyc + 1 || first_pop_cyc < 0) begin
      errors++; $display("FAIL outst_9th: 9th grant at cycle %0d, need %0d (first pop + 1)", grant_cyc, first_pop_cyc + 1);
    end
    drain();
    checks++; if (ar_cnt - base != 9) begin errors++; $display("FAIL outst_total: got %0d AR, need 9", ar_cnt - base); end
  endtask

  task automatic test_interleave();
    clear_stats();
    r_en = 1'b1; r_rand = 1'b1; rd_rand = 1'b1;
    do_req(1'b0, 32'h4000_0000, 4'd15);
    do_req(1'b1, 32'h4100_0100, 4'd15);
    do_req(1'b0, 32'h4000_0800, 4'd15);
    drain();
    checks++;
    if (beats0 != 32 || beats1 != 16) begin errors++; $display("FAIL il_beats: got %0d/%0d, need 32/16", beats0, beats1); end
    checks++;
    if (last_pos.size() != 3 || last_pos[0] != 16 || last_pos[1] != 32 || last_pos[2] != 48) begin
      errors++; $display("FAIL il_last: got %0d last beats (first at %0d), need 3 at 16/32/48",
                         last_pos.size(), (last_pos.size() > 0) ? last_pos[0] : -1);
    end
  endtask

  task automatic test_addr_align();
    logic [31:0] first_addr;
    r_en = 1'b1; r_rand = 1'b0; rd_rand = 1'b0;
    ar_en = 1'b0;
    do_req(1'b1, 32'h2100_0805, 4'd3);
    for (int i = 0; i < 3; i++) begin
      #2;
      if (i == 0) first_addr = m_axi_araddr;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h2100_0800 || m_axi_araddr !== first_addr ||
          m_axi_arlen !== 4'd3 || m_axi_arid !== 6'd1 || m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01) begin
        errors++;
        $display("FAIL align_hold: got v=%b addr=%h len=%0d id=%0d size=%0d burst=%0d, need v=1 addr=21000800 len=3 id=1 size=3 burst=1",
                 m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst);
      end
      @(posedge m_axi_clk); #1;
    end
    ar_en = 1'b1;
    drain();
  endtask

  task automatic test_unexp_r();
    @(posedge m_axi_clk); #1;
    force_rv = 1'b1;
    #2;
    checks++; if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL unexp_rready: got %b, need 0", m_axi_rready); end
    checks++; if (err_unexp_r !== 1'b0) begin errors++; $display("FAIL unexp_early: got %b, need 0", err_unexp_r); end
    @(posedge m_axi_clk); #1;
    force_rv = 1'b0;
    #2;
    checks++; if (err_unexp_r !== 1'b1) begin errors++; $display("FAIL unexp_set: got %b, need 1", err_unexp_r); end
    repeat (5) @(posedge m_axi_clk);
    #3;
    checks++; if (err_unexp_r !== 1'b1) begin errors++; $display("FAIL unexp_hold: got %b, need 1", err_unexp_r); end
  endtask

  task automatic test_reset_mid();
    int base, n = 0;
    r_en = 1'b0; r_rand = 1'b0; rd_rand = 1'b0;
    base = ar_cnt;
    do_req(1'b0, 32'h5000_0000, 4'd3);
    do_req(1'b1, 32'h5100_0000, 4'd3);
    do_req(1'b0, 32'h5000_0040, 4'd3);
    while (ar_cnt < base + 3 && n < 100) begin @(posedge m_axi_clk); #5; n++; end
    checks++; if (ar_cnt != base + 3) begin errors++; $display("FAIL mid_setup: got %0d AR, need 3", ar_cnt - base); end
    @(posedge m_axi_clk); #1;
    m_axi_rst = 1'b1;
    #2;
    checks++;
    if (m_axi_arvalid !== 1'b0 || rd0_valid !== 1'b0 || rd1_valid !== 1'b0 || err_unexp_r !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got arvalid=%b rd=%b%b err=%b, need all 0", m_axi_arvalid, rd0_valid, rd1_valid, err_unexp_r);
    end
    repeat (2) @(posedge m_axi_clk);
    @(posedge m_axi_clk); #1;
    m_axi_rst = 1'b0;
    force_rv = 1'b1;
    #2;
    checks++;
    if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0 || m_axi_rready !== 1'b0) begin
      errors++; $display("FAIL mid_flush: got rd=%b%b rready=%b, need 000", rd0_valid, rd1_valid, m_axi_rready);
    end
    @(posedge m_axi_clk); #1;
    force_rv = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'h6000_0000; req0_len = 4'd0;
    req1_valid = 1'b1; req1_addr = 32'h6100_0000; req1_len = 4'd0;
    #2;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_first: got ready=%b%b, need req0 (10)", req0_ready, req1_ready);
    end
    if (req0_ready) exp_ar.push_back('{32'h6000_0000, 4'd0, 1'b0});
    if (req1_ready) exp_ar.push_back('{32'h6100_0000, 4'd0, 1'b1});
    @(posedge m_axi_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    r_en = 1'b1;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding();
    test_interleave();
    test_addr_align();
    test_unexp_r();
    test_reset_mid();
    repeat (3) @(posedge m_axi_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
